// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared state enum, default sizing and counter width
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH   = 16384;
  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// rtl/data_mem_responder_dmem_array.sv - single-port word storage, sync write, comb read, no reset
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder with request/response handshakes
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             lat_err;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // Error is judged from the latched address so later req_* activity cannot affect it
  assign lat_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  dmem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_q[IDX_W+1:2]),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Store commit and load capture share this edge, so a load sees every earlier store
          state_d = RESP;
          mem_we  = write_q && !lat_err;
          err_d   = lat_err;
          rdata_d = (write_q || lat_err) ? 32'd0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
